// File: rtl/fft_twiddle_sequencer.sv
// Radix-2 FFT stage/butterfly scheduler: walks every stage, drives the twiddle LUT span
// and streams recursively generated twiddles with butterfly operand addresses.
module fft_twiddle_sequencer #(
    parameter int BITS      = 24,
    parameter int FRAC      = 21,
    parameter int MAX_LOG2N = 7
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [2:0]             log2n,
    output logic                   busy,
    output logic                   done,
    output logic                   lut_on,
    output logic [10:0]            lut_h,
    input  logic signed [BITS-1:0] cos_in,
    input  logic signed [BITS-1:0] sin_in,
    output logic                   tw_valid,
    input  logic                   tw_ready,
    output logic signed [BITS-1:0] tw_re,
    output logic signed [BITS-1:0] tw_im,
    output logic [MAX_LOG2N-1:0]   addr_top,
    output logic [MAX_LOG2N-1:0]   addr_bot,
    output logic [2:0]             tw_stage
);

    localparam int AW = MAX_LOG2N;
    localparam int PW = 2 * BITS;
    localparam logic signed [BITS-1:0] ONE = BITS'(1 << FRAC);
    localparam logic signed [PW-1:0]   RND = PW'(1) << (FRAC - 1);

    typedef enum logic [1:0] {IDLE, SETH, EMIT, FIN} state_t;

    state_t                 state, state_nxt;
    logic [2:0]             n_log, s;
    logic [AW-1:0]          g, k, g_last, k_last, half, hstep;
    logic [AW:0]            g_span;
    logic signed [BITS-1:0] w_re, w_im, wf_re, wf_im, nxt_re, nxt_im;
    logic signed [PW-1:0]   p_rr, p_ii, p_ri, p_ir;
    logic                   start_ok, hs, g_wrap, k_wrap;

    function automatic logic signed [BITS-1:0] rnd_frac(input logic signed [PW-1:0] acc);
        logic signed [PW-1:0] t;
        t = (acc + RND) >>> FRAC;
        return t[BITS-1:0];
    endfunction

    assign start_ok = (log2n != 3'd0) && (int'(log2n) <= MAX_LOG2N);
    assign g_span   = (AW+1)'(1) << (n_log - s);
    assign g_last   = AW'(g_span - (AW+1)'(1));
    assign k_last   = AW'((lut_h >> 1) - 11'd1);
    assign half     = AW'(lut_h >> 1);
    assign hstep    = AW'(lut_h);
    assign hs       = tw_valid & tw_ready;
    assign g_wrap   = (g == g_last);
    assign k_wrap   = (k == k_last);

    // w * W with round-half-up on the fractional shift, wrapping to BITS
    assign p_rr   = PW'(w_re) * PW'(wf_re);
    assign p_ii   = PW'(w_im) * PW'(wf_im);
    assign p_ri   = PW'(w_re) * PW'(wf_im);
    assign p_ir   = PW'(w_im) * PW'(wf_re);
    assign nxt_re = rnd_frac(p_rr - p_ii);
    assign nxt_im = rnd_frac(p_ri + p_ir);

    assign tw_re    = w_re;
    assign tw_im    = w_im;
    assign tw_stage = s;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        lut_on    = 1'b0;
        tw_valid  = 1'b0;
        case (state)
            IDLE: if (start) state_nxt = start_ok ? SETH : FIN;
            SETH: begin
                busy      = 1'b1;
                lut_on    = 1'b1;
                state_nxt = EMIT;
            end
            EMIT: begin
                busy     = 1'b1;
                lut_on   = 1'b1;
                tw_valid = 1'b1;
                if (hs && g_wrap && k_wrap) state_nxt = (s == n_log) ? FIN : SETH;
            end
            FIN: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            n_log    <= '0;
            s        <= '0;
            lut_h    <= '0;
            g        <= '0;
            k        <= '0;
            w_re     <= '0;
            w_im     <= '0;
            wf_re    <= '0;
            wf_im    <= '0;
            addr_top <= '0;
            addr_bot <= '0;
        end else begin
            case (state)
                IDLE: if (start && start_ok) begin
                    n_log <= log2n;
                    s     <= 3'd1;
                    lut_h <= 11'd2;
                end
                SETH: begin
                    wf_re    <= cos_in;
                    wf_im    <= -sin_in;
                    w_re     <= ONE;
                    w_im     <= '0;
                    g        <= '0;
                    k        <= '0;
                    addr_top <= '0;
                    addr_bot <= half;
                end
                EMIT: if (hs) begin
                    if (!g_wrap) begin
                        g        <= g + AW'(1);
                        addr_top <= addr_top + hstep;
                        addr_bot <= addr_bot + hstep;
                    end else if (!k_wrap) begin
                        g        <= '0;
                        k        <= k + AW'(1);
                        addr_top <= k + AW'(1);
                        addr_bot <= k + AW'(1) + half;
                        w_re     <= nxt_re;
                        w_im     <= nxt_im;
                    end else if (s != n_log) begin
                        s     <= s + 3'd1;
                        lut_h <= lut_h << 1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fft_twiddle_sequencer.sv
// Bench for fft_twiddle_sequencer: trig LUT environment plus a loop-nest reference
// of the twiddle/address schedule, with random backpressure and start spam.
module tb_fft_twiddle_sequencer;

    localparam int BITS = 24;
    localparam int FRAC = 21;
    localparam int MAXL = 7;
    localparam int BUDGET = 20000;

    logic                   clk = 1'b0;
    logic                   rst, start, tw_ready;
    logic [2:0]             log2n;
    logic                   busy, done, lut_on, tw_valid;
    logic [10:0]            lut_h;
    logic signed [BITS-1:0] cos_in, sin_in, tw_re, tw_im;
    logic [MAXL-1:0]        addr_top, addr_bot;
    logic [2:0]             tw_stage;

    typedef struct {
        int re;
        int im;
        int top;
        int bot;
        int stg;
    } beat_t;

    beat_t exp_q[$];
    beat_t act_q[$];
    int    luth_q[$];
    int    tests = 0;
    int    fails = 0;

    fft_twiddle_sequencer #(.BITS(BITS), .FRAC(FRAC), .MAX_LOG2N(MAXL)) dut (
        .clk(clk), .rst(rst), .start(start), .log2n(log2n),
        .busy(busy), .done(done), .lut_on(lut_on), .lut_h(lut_h),
        .cos_in(cos_in), .sin_in(sin_in),
        .tw_valid(tw_valid), .tw_ready(tw_ready),
        .tw_re(tw_re), .tw_im(tw_im),
        .addr_top(addr_top), .addr_bot(addr_bot), .tw_stage(tw_stage)
    );

    always #5 clk = ~clk;

    function automatic int to_fix(real v);
        real x;
        x = v * 2097152.0;
        return $rtoi(x >= 0.0 ? x + 0.5 : x - 0.5);
    endfunction

    function automatic int lut_cos(int h);
        if (h <= 0) return 0;
        return to_fix($cos(2.0 * 3.14159265358979323846 / h));
    endfunction

    function automatic int lut_sin(int h);
        if (h <= 0) return 0;
        return to_fix($sin(2.0 * 3.14159265358979323846 / h));
    endfunction

    always_comb begin
        cos_in = BITS'(lut_cos(int'(lut_h)));
        sin_in = BITS'(lut_sin(int'(lut_h)));
    end

    function automatic int wrap24(longint v);
        logic signed [23:0] t;
        t = v[23:0];
        return int'(t);
    endfunction

    function automatic int rnd_shift(longint acc);
        return wrap24((acc + (64'sd1 <<< (FRAC - 1))) >>> FRAC);
    endfunction

    task automatic build_exp(input int l2n);
        int n, h, cw_re, cw_im, wr, wi, nr, ni;
        exp_q.delete();
        if (l2n < 1 || l2n > MAXL) return;
        n = 1 << l2n;
        for (int s = 1; s <= l2n; s++) begin
            h = 1 << s;
            cw_re = lut_cos(h);
            cw_im = -lut_sin(h);
            wr = 1 << FRAC;
            wi = 0;
            for (int k = 0; k < h / 2; k++) begin
                for (int g = 0; g < n / h; g++)
                    exp_q.push_back('{wr, wi, g * h + k, g * h + k + h / 2, s});
                nr = rnd_shift(longint'(wr) * cw_re - longint'(wi) * cw_im);
                ni = rnd_shift(longint'(wr) * cw_im + longint'(wi) * cw_re);
                wr = nr;
                wi = ni;
            end
        end
    endtask

    task automatic run_xfer(input int l2n, input int pct, input bit spam,
                            output int first_v, output int done_cyc, output int ndone);
        int    cyc, nexp, nbeats;
        bit    stalled;
        beat_t cur, prev, e;
        build_exp(l2n);
        nexp = exp_q.size();
        act_q.delete();
        luth_q.delete();
        first_v = -1;
        done_cyc = -1;
        ndone = 0;
        stalled = 0;
        cyc = 0;
        @(negedge clk);
        start = 1'b1;
        log2n = 3'(l2n);
        tw_ready = 1'b0;
        while (cyc < BUDGET) begin
            @(negedge clk);
            cyc++;
            start = spam ? 1'($urandom_range(0, 1)) : 1'b0;
            if (spam) log2n = 3'($urandom_range(0, 7));
            cur = '{int'(tw_re), int'(tw_im), int'(addr_top), int'(addr_bot), int'(tw_stage)};
            if (stalled) begin
                tests++;
                if (tw_valid !== 1'b1 || cur.re != prev.re || cur.im != prev.im ||
                    cur.top != prev.top || cur.bot != prev.bot || cur.stg != prev.stg) begin
                    fails++;
                    $display("FAIL stall_hold l2n=%0d cyc=%0d got v=%0b (%0d,%0d) %0d/%0d s%0d want held (%0d,%0d) %0d/%0d s%0d",
                             l2n, cyc, tw_valid, cur.re, cur.im, cur.top, cur.bot, cur.stg,
                             prev.re, prev.im, prev.top, prev.bot, prev.stg);
                end
            end
            if (tw_valid === 1'b1 && first_v < 0) first_v = cyc;
            if (busy === 1'b1 && tw_valid === 1'b0) luth_q.push_back(int'(lut_h));
            if (lut_on !== busy) begin
                tests++;
                fails++;
                $display("FAIL lut_on_vs_busy cyc=%0d got lut_on=%0b want %0b", cyc, lut_on, busy);
            end
            if (done === 1'b1) begin
                ndone++;
                done_cyc = cyc;
                start = 1'b0;
                tests++;
                if (busy !== 1'b0 || tw_valid !== 1'b0) begin
                    fails++;
                    $display("FAIL done_idle l2n=%0d got busy=%0b valid=%0b want 0/0", l2n, busy, tw_valid);
                end
                break;
            end
            tw_ready = ($urandom_range(0, 99) < pct);
            stalled = 0;
            if (tw_valid === 1'b1) begin
                if (tw_ready) begin
                    act_q.push_back(cur);
                    tests++;
                    if (exp_q.size() == 0) begin
                        fails++;
                        $display("FAIL extra_beat l2n=%0d got (%0d,%0d) %0d/%0d s%0d want none",
                                 l2n, cur.re, cur.im, cur.top, cur.bot, cur.stg);
                    end else begin
                        e = exp_q.pop_front();
                        if (cur.re != e.re || cur.im != e.im || cur.top != e.top ||
                            cur.bot != e.bot || cur.stg != e.stg) begin
                            fails++;
                            $display("FAIL beat l2n=%0d idx=%0d got (%0d,%0d) %0d/%0d s%0d want (%0d,%0d) %0d/%0d s%0d",
                                     l2n, act_q.size() - 1, cur.re, cur.im, cur.top, cur.bot, cur.stg,
                                     e.re, e.im, e.top, e.bot, e.stg);
                        end
                    end
                end else begin
                    stalled = 1;
                    prev = cur;
                end
            end
        end
        start = 1'b0;
        tw_ready = 1'b0;
        tests++;
        if (done_cyc < 0) begin
            fails++;
            $display("FAIL timeout l2n=%0d got no done within %0d cycles want done", l2n, BUDGET);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (done === 1'b1) ndone++;
            if (tw_valid === 1'b1) first_v = (first_v < 0) ? 9999 : first_v;
        end
        nbeats = act_q.size();
        tests++;
        if (nbeats != nexp || exp_q.size() != 0 || ndone != 1) begin
            fails++;
            $display("FAIL beat_count l2n=%0d got beats=%0d dones=%0d want beats=%0d dones=1",
                     l2n, nbeats, ndone, nexp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        tests++;
        if (busy !== 0 || done !== 0 || lut_on !== 0 || tw_valid !== 0 || lut_h !== 0 ||
            tw_re !== 0 || tw_im !== 0 || addr_top !== 0 || addr_bot !== 0 || tw_stage !== 0) begin
            fails++;
            $display("FAIL %s got busy=%0b done=%0b on=%0b v=%0b h=%0d tw=(%0d,%0d) a=%0d/%0d s=%0d want all 0",
                     tag, busy, done, lut_on, tw_valid, lut_h, tw_re, tw_im, addr_top, addr_bot, tw_stage);
        end
    endtask

    task automatic test_reset();
        int seen_done;
        rst = 1'b1;
        start = 1'b0;
        log2n = 3'd0;
        tw_ready = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset_state");
        rst = 1'b0;
        start = 1'b1;
        log2n = 3'd3;
        tw_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        tests++;
        if (tw_valid !== 1'b1 || busy !== 1'b1) begin
            fails++;
            $display("FAIL mid_emit got v=%0b busy=%0b want 1/1", tw_valid, busy);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_all_zero("reset_mid_emit");
        seen_done = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1 || tw_valid === 1'b1) seen_done++;
        end
        tests++;
        if (seen_done != 0) begin
            fails++;
            $display("FAIL reset_no_done got %0d active cycles want 0", seen_done);
        end
        tw_ready = 1'b0;
    endtask

    task automatic test_single();
        int fv, dc, nd;
        run_xfer(1, 100, 0, fv, dc, nd);
        tests++;
        if (fv != 2 || dc != 3) begin
            fails++;
            $display("FAIL single_timing got first=%0d done=%0d want 2/3", fv, dc);
        end
        tests++;
        if (act_q.size() != 1 || act_q[0].re != 2097152 || act_q[0].im != 0 ||
            act_q[0].top != 0 || act_q[0].bot != 1 || act_q[0].stg != 1) begin
            fails++;
            $display("FAIL single_beat got n=%0d want one beat (2097152,0) 0/1 s1", act_q.size());
        end
    endtask

    task automatic test_n8();
        int fv, dc, nd;
        run_xfer(3, 100, 0, fv, dc, nd);
        tests++;
        if (fv != 2 || dc != 16) begin
            fails++;
            $display("FAIL n8_timing got first=%0d done=%0d want 2/16", fv, dc);
        end
        tests++;
        if (luth_q.size() != 3 || luth_q[0] != 2 || luth_q[1] != 4 || luth_q[2] != 8) begin
            fails++;
            $display("FAIL n8_lut_h got n=%0d want seq 2,4,8", luth_q.size());
        end
        tests++;
        if (act_q.size() != 12 || act_q[3].top != 6 || act_q[3].bot != 7 ||
            act_q[6].re != 0 || act_q[6].im != -2097152 || act_q[6].top != 1 || act_q[6].bot != 3) begin
            fails++;
            $display("FAIL n8_stage2 got n=%0d want 12 beats, beat6=(0,-2097152) 1/3", act_q.size());
        end
        tests++;
        if (act_q.size() != 12 || act_q[9].re != 1482910 || act_q[9].im != -1482910 ||
            act_q[9].top != 1 || act_q[9].bot != 5 || act_q[9].stg != 3) begin
            fails++;
            $display("FAIL n8_stage3_w1 got n=%0d want beat9=(1482910,-1482910) 1/5 s3", act_q.size());
        end
        tests++;
        if (lut_h !== 11'd8) begin
            fails++;
            $display("FAIL lut_h_hold got %0d want 8", lut_h);
        end
    endtask

    task automatic test_backpressure();
        int fv, dc, nd;
        run_xfer(4, 45, 0, fv, dc, nd);
        tests++;
        if (act_q.size() != 32) begin
            fails++;
            $display("FAIL bp_beats got %0d want 32", act_q.size());
        end
    endtask

    task automatic test_back_to_back();
        int fv, dc, nd;
        run_xfer(5, 70, 1, fv, dc, nd);
        tests++;
        if (act_q.size() != 80 || nd != 1) begin
            fails++;
            $display("FAIL spam_start got beats=%0d dones=%0d want 80/1", act_q.size(), nd);
        end
        run_xfer(2, 100, 1, fv, dc, nd);
        tests++;
        if (dc != 1 + 2 * 3) begin
            fails++;
            $display("FAIL b2b_timing got done=%0d want 7", dc);
        end
    endtask

    task automatic test_invalid();
        int fv, dc, nd;
        for (int i = 0; i < 2; i++) begin
            run_xfer(0, 100, 0, fv, dc, nd);
            tests++;
            if (dc != 1 || fv != -1 || act_q.size() != 0) begin
                fails++;
                $display("FAIL invalid_l2n got done=%0d first_valid=%0d beats=%0d want 1/-1/0",
                         dc, fv, act_q.size());
            end
        end
    endtask

    task automatic test_random();
        int fv, dc, nd, l2n, pct;
        for (int i = 0; i < 5; i++) begin
            l2n = (i == 0) ? 7 : $urandom_range(1, 7);
            pct = $urandom_range(30, 100);
            run_xfer(l2n, pct, 1'($urandom_range(0, 1)), fv, dc, nd);
            tests++;
            if (fv != 2) begin
                fails++;
                $display("FAIL rand_first l2n=%0d got first=%0d want 2", l2n, fv);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_n8();
        test_backpressure();
        test_back_to_back();
        test_invalid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
